// File: rtl/mm_line_responder.sv
// mm_line_responder: main-memory line responder for the L1 fill/writeback port.
// Services one 256b line read or write at a time, each with a fixed programmable
// latency. Requests arriving while a transaction is outstanding are dropped
// and flagged on err.
// Optional feature: define MM_RESP_WRACK_EN to add the wr_ack commit strobe port.
module mm_line_responder #(
  parameter int unsigned LINE_W    = 256,
  parameter int unsigned MEM_RANGE = 256,
  parameter int unsigned RD_LAT    = 4,
  parameter int unsigned WR_LAT    = 2
) (
  input  logic              master_clk,
  input  logic              reset,
  input  logic [31:0]       mm_a,
  input  logic              mm_read,
  input  logic              mm_write,
  input  logic [LINE_W-1:0] mm_wd,
  output logic [LINE_W-1:0] mm_rd,
  output logic              mm_valid,
  output logic              busy,
`ifdef MM_RESP_WRACK_EN
  output logic              err,
  output logic              wr_ack
`else
  output logic              err
`endif
);

  localparam int unsigned IDX_W = (MEM_RANGE > 1) ? $clog2(MEM_RANGE) : 1;
  localparam int unsigned WORDS = LINE_W / 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [3:0]         lat_cnt_q, lat_cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               oor_q, oor_d;
  logic [LINE_W-1:0]  wdata_q, wdata_d;
  logic               mm_valid_q, mm_valid_d;
  logic [LINE_W-1:0]  mm_rd_q, mm_rd_d;
  logic               busy_q, busy_d;
  logic               err_q, err_d;
`ifdef MM_RESP_WRACK_EN
  logic               wr_ack_q, wr_ack_d;
`endif

  logic [LINE_W-1:0]  mem_q [MEM_RANGE];
  logic               mem_we;

  logic               req_oor;
  logic [IDX_W-1:0]   req_idx;
  logic               unused_addr_lsbs;

  // Byte offset within a line carries no meaning for a line-granular memory.
  assign unused_addr_lsbs = ^mm_a[4:0];

  assign req_oor = ({5'b0, mm_a[31:5]} >= MEM_RANGE);
  assign req_idx = mm_a[5 +: IDX_W];

  // Boot image: every 32b word holds its own byte address; reset never touches it.
  initial begin
    for (int unsigned i = 0; i < MEM_RANGE; i++) begin
      for (int unsigned k = 0; k < WORDS; k++) begin
        mem_q[i][32*k +: 32] = 32'(i*32 + 4*k);
      end
    end
  end

  // Next-state and response logic for the single-outstanding-request FSM.
  always_comb begin
    state_d    = state_q;
    lat_cnt_d  = lat_cnt_q;
    idx_d      = idx_q;
    oor_d      = oor_q;
    wdata_d    = wdata_q;
    mm_valid_d = 1'b0;
    mm_rd_d    = '0;
    busy_d     = busy_q;
    err_d      = 1'b0;
    mem_we     = 1'b0;
`ifdef MM_RESP_WRACK_EN
    wr_ack_d   = 1'b0;
`endif

    unique case (state_q)
      IDLE: begin
        // A write wins over a simultaneous read; the read is dropped and flagged.
        if (mm_write) begin
          state_d   = WR_WAIT;
          lat_cnt_d = 4'(WR_LAT - 1);
          idx_d     = req_idx;
          oor_d     = req_oor;
          wdata_d   = mm_wd;
          busy_d    = 1'b1;
          err_d     = mm_read | req_oor;
        end else if (mm_read) begin
          state_d   = RD_WAIT;
          lat_cnt_d = 4'(RD_LAT - 1);
          idx_d     = req_idx;
          oor_d     = req_oor;
          busy_d    = 1'b1;
          err_d     = req_oor;
        end
      end

      RD_WAIT: begin
        err_d = mm_read | mm_write;
        if (lat_cnt_q == 4'd0) begin
          mm_valid_d = 1'b1;
          mm_rd_d    = oor_q ? '0 : mem_q[idx_q];
          busy_d     = 1'b0;
          state_d    = IDLE;
        end else begin
          lat_cnt_d = lat_cnt_q - 4'd1;
        end
      end

      WR_WAIT: begin
        err_d = mm_read | mm_write;
        if (lat_cnt_q == 4'd0) begin
          mem_we  = ~oor_q & ~reset;
          busy_d  = 1'b0;
          state_d = IDLE;
`ifdef MM_RESP_WRACK_EN
          wr_ack_d = 1'b1;
`endif
        end else begin
          lat_cnt_d = lat_cnt_q - 4'd1;
        end
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge master_clk) begin
    if (reset) begin
      state_q    <= IDLE;
      lat_cnt_q  <= '0;
      idx_q      <= '0;
      oor_q      <= 1'b0;
      wdata_q    <= '0;
      mm_valid_q <= 1'b0;
      mm_rd_q    <= '0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef MM_RESP_WRACK_EN
      wr_ack_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      lat_cnt_q  <= lat_cnt_d;
      idx_q      <= idx_d;
      oor_q      <= oor_d;
      wdata_q    <= wdata_d;
      mm_valid_q <= mm_valid_d;
      mm_rd_q    <= mm_rd_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
`ifdef MM_RESP_WRACK_EN
      wr_ack_q   <= wr_ack_d;
`endif
    end
  end

  // Line array commit; the write enable already excludes reset and out-of-range lines.
  always_ff @(posedge master_clk) begin
    if (mem_we) begin
      mem_q[idx_q] <= wdata_q;
    end
  end

  assign mm_rd    = mm_rd_q;
  assign mm_valid = mm_valid_q;
  assign busy     = busy_q;
  assign err      = err_q;
`ifdef MM_RESP_WRACK_EN
  assign wr_ack   = wr_ack_q;
`endif

endmodule

// File: tb/tb_mm_line_responder.sv
// Testbench for mm_line_responder: directed scenarios plus a randomized
// transaction stream checked against a line-array reference model.
module tb_mm_line_responder;

  localparam int unsigned LINE_W    = 256;
  localparam int unsigned MEM_RANGE = 256;
  localparam int unsigned RD_LAT    = 4;
  localparam int unsigned WR_LAT    = 2;

  logic              master_clk = 1'b0;
  logic              reset      = 1'b1;
  logic [31:0]       mm_a       = '0;
  logic              mm_read    = 1'b0;
  logic              mm_write   = 1'b0;
  logic [LINE_W-1:0] mm_wd      = '0;
  logic [LINE_W-1:0] mm_rd;
  logic              mm_valid;
  logic              busy;
  logic              err;
`ifdef MM_RESP_WRACK_EN
  logic              wr_ack;
`endif

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  logic [LINE_W-1:0] model_mem [MEM_RANGE];

  mm_line_responder #(
    .LINE_W    (LINE_W),
    .MEM_RANGE (MEM_RANGE),
    .RD_LAT    (RD_LAT),
    .WR_LAT    (WR_LAT)
  ) dut (
    .master_clk (master_clk),
    .reset      (reset),
    .mm_a       (mm_a),
    .mm_read    (mm_read),
    .mm_write   (mm_write),
    .mm_wd      (mm_wd),
    .mm_rd      (mm_rd),
    .mm_valid   (mm_valid),
    .busy       (busy),
`ifdef MM_RESP_WRACK_EN
    .err        (err),
    .wr_ack     (wr_ack)
`else
    .err        (err)
`endif
  );

  always #5 master_clk = ~master_clk;

  // Boot pattern: each word equals its own byte address.
  function automatic logic [LINE_W-1:0] boot_line(int unsigned line);
    logic [LINE_W-1:0] v;
    for (int unsigned k = 0; k < LINE_W/32; k++) v[32*k +: 32] = 32'(line*32 + 4*k);
    return v;
  endfunction

  function automatic logic [LINE_W-1:0] model_read(logic [31:0] a);
    if (32'(a[31:5]) >= MEM_RANGE) return '0;
    return model_mem[a[12:5]];
  endfunction

  function automatic logic [LINE_W-1:0] rand_line();
    logic [LINE_W-1:0] v;
    for (int unsigned k = 0; k < LINE_W/32; k++) v[32*k +: 32] = $urandom;
    return v;
  endfunction

  // Advance one clock and settle just past the edge before sampling.
  task automatic step();
    @(posedge master_clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    mm_read = 1'b0; mm_write = 1'b0;
    step(); step();
    vectors++;
    if ({mm_valid, busy, err} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_flags got v/b/e=%b required 000", {mm_valid, busy, err});
    end
    vectors++;
    if (mm_rd !== '0) begin
      miscompares++;
      $display("FAIL reset_rd got %h required 0", mm_rd);
    end
`ifdef MM_RESP_WRACK_EN
    vectors++;
    if (wr_ack !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_wrack got %b required 0", wr_ack);
    end
`endif
    reset = 1'b0;
  endtask

  task automatic test_read_latency();
    logic exp_v;
    mm_a = 32'h0000_0040; mm_read = 1'b1;
    step();
    mm_read = 1'b0;
    vectors++;
    if ({mm_valid, busy, err} !== 3'b010) begin
      miscompares++;
      $display("FAIL rd_accept got v/b/e=%b required 010", {mm_valid, busy, err});
    end
    for (int unsigned m = 1; m <= RD_LAT; m++) begin
      step();
      exp_v = (m == RD_LAT);
      vectors++;
      if ({mm_valid, busy} !== {exp_v, ~exp_v}) begin
        miscompares++;
        $display("FAIL rd_timing cyc%0d got v/b=%b required %b", m, {mm_valid, busy}, {exp_v, ~exp_v});
      end
    end
    vectors++;
    if (mm_rd !== model_read(32'h40)) begin
      miscompares++;
      $display("FAIL rd_data got %h required %h", mm_rd, model_read(32'h40));
    end
    step();
    vectors++;
    if ({mm_valid, mm_rd} !== {1'b0, {LINE_W{1'b0}}}) begin
      miscompares++;
      $display("FAIL rd_strobe_end got v=%b rd=%h required 0/0", mm_valid, mm_rd);
    end
  endtask

  task automatic test_write_then_read();
    logic [LINE_W-1:0] wd;
    wd = {8{32'hDEADBEEF}};
    mm_a = 32'h0000_0020; mm_wd = wd; mm_write = 1'b1;
    step();
    mm_write = 1'b0;
    for (int unsigned m = 1; m <= WR_LAT; m++) begin
      step();
      vectors++;
      if ({mm_valid, busy} !== {1'b0, m < WR_LAT}) begin
        miscompares++;
        $display("FAIL wr_timing cyc%0d got v/b=%b required %b", m, {mm_valid, busy}, {1'b0, m < WR_LAT});
      end
`ifdef MM_RESP_WRACK_EN
      vectors++;
      if (wr_ack !== (m == WR_LAT)) begin
        miscompares++;
        $display("FAIL wr_ack cyc%0d got %b required %b", m, wr_ack, m == WR_LAT);
      end
`endif
    end
    model_mem[1] = wd;
    mm_read = 1'b1;
    step();
    mm_read = 1'b0;
    repeat (RD_LAT) step();
    vectors++;
    if ({mm_valid, mm_rd} !== {1'b1, model_read(32'h20)}) begin
      miscompares++;
      $display("FAIL raw_data got v=%b rd=%h required 1/%h", mm_valid, mm_rd, model_read(32'h20));
    end
  endtask

  task automatic test_busy_drop();
    int unsigned nvalid;
    nvalid = 0;
    mm_a = 32'h0000_0100; mm_read = 1'b1;
    step();
    step();
    mm_read = 1'b0;
    vectors++;
    if ({busy, err} !== 2'b11) begin
      miscompares++;
      $display("FAIL drop_err got b/e=%b required 11", {busy, err});
    end
    for (int unsigned i = 0; i < RD_LAT + 3; i++) begin
      step();
      if (i == 0) begin
        vectors++;
        if (err !== 1'b0) begin
          miscompares++;
          $display("FAIL drop_err_pulse got %b required 0", err);
        end
      end
      if (mm_valid === 1'b1) begin
        nvalid++;
        vectors++;
        if (mm_rd !== model_read(32'h100)) begin
          miscompares++;
          $display("FAIL drop_data got %h required %h", mm_rd, model_read(32'h100));
        end
      end
    end
    vectors++;
    if (nvalid != 1) begin
      miscompares++;
      $display("FAIL drop_valid_count got %0d required 1", nvalid);
    end
  endtask

  task automatic test_rw_conflict();
    int unsigned nvalid;
    nvalid = 0;
    mm_a = 32'h0000_0060; mm_wd = '0; mm_read = 1'b1; mm_write = 1'b1;
    step();
    mm_read = 1'b0; mm_write = 1'b0;
    vectors++;
    if ({busy, err} !== 2'b11) begin
      miscompares++;
      $display("FAIL conflict_err got b/e=%b required 11", {busy, err});
    end
    for (int unsigned i = 0; i < RD_LAT + 2; i++) begin
      step();
      if (mm_valid === 1'b1) nvalid++;
    end
    vectors++;
    if (nvalid != 0) begin
      miscompares++;
      $display("FAIL conflict_valid_count got %0d required 0", nvalid);
    end
    model_mem[3] = '0;
    mm_read = 1'b1;
    step();
    mm_read = 1'b0;
    repeat (RD_LAT) step();
    vectors++;
    if ({mm_valid, mm_rd} !== {1'b1, model_read(32'h60)}) begin
      miscompares++;
      $display("FAIL conflict_rdback got v=%b rd=%h required 1/%h", mm_valid, mm_rd, model_read(32'h60));
    end
  endtask

  task automatic test_out_of_range();
    // Line 256 read: error flag at accept, zero data at normal latency.
    mm_a = 32'h0000_2000; mm_read = 1'b1;
    step();
    mm_read = 1'b0;
    vectors++;
    if ({mm_valid, busy, err} !== 3'b011) begin
      miscompares++;
      $display("FAIL oor_rd_accept got v/b/e=%b required 011", {mm_valid, busy, err});
    end
    repeat (RD_LAT) step();
    vectors++;
    if ({mm_valid, err, mm_rd} !== {2'b10, {LINE_W{1'b0}}}) begin
      miscompares++;
      $display("FAIL oor_rd_resp got v=%b e=%b rd=%h required 1/0/0", mm_valid, err, mm_rd);
    end
    // Line 256 write aliases index 0 in the low bits; line 0 must stay intact.
    mm_a = 32'h0000_2000; mm_wd = rand_line(); mm_write = 1'b1;
    step();
    mm_write = 1'b0;
    vectors++;
    if ({busy, err} !== 2'b11) begin
      miscompares++;
      $display("FAIL oor_wr_accept got b/e=%b required 11", {busy, err});
    end
    repeat (WR_LAT) step();
`ifdef MM_RESP_WRACK_EN
    vectors++;
    if (wr_ack !== 1'b1) begin
      miscompares++;
      $display("FAIL oor_wr_ack got %b required 1", wr_ack);
    end
`endif
    mm_a = 32'h0000_0000; mm_read = 1'b1;
    step();
    mm_read = 1'b0;
    repeat (RD_LAT) step();
    vectors++;
    if ({mm_valid, mm_rd} !== {1'b1, model_read(32'h0)}) begin
      miscompares++;
      $display("FAIL oor_wr_suppressed got v=%b rd=%h required 1/%h", mm_valid, mm_rd, model_read(32'h0));
    end
  endtask

  task automatic test_reset_mid_write();
    int unsigned nack;
    nack = 0;
    mm_a = 32'h0000_0080; mm_wd = rand_line(); mm_write = 1'b1;
    step();
    mm_write = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    vectors++;
    if ({mm_valid, busy, err} !== 3'b000) begin
      miscompares++;
      $display("FAIL midrst_flags got v/b/e=%b required 000", {mm_valid, busy, err});
    end
    for (int unsigned i = 0; i < 4; i++) begin
      step();
`ifdef MM_RESP_WRACK_EN
      if (wr_ack === 1'b1) nack++;
`endif
      if (mm_valid === 1'b1 || busy === 1'b1) nack++;
    end
    vectors++;
    if (nack != 0) begin
      miscompares++;
      $display("FAIL midrst_activity got %0d events required 0", nack);
    end
    mm_read = 1'b1;
    step();
    mm_read = 1'b0;
    repeat (RD_LAT) step();
    vectors++;
    if ({mm_valid, mm_rd} !== {1'b1, model_read(32'h80)}) begin
      miscompares++;
      $display("FAIL midrst_nocommit got v=%b rd=%h required 1/%h", mm_valid, mm_rd, model_read(32'h80));
    end
  endtask

  // Random stream: back-to-back requests, conflicts, drops while busy, out-of-range lines.
  task automatic test_random();
    int unsigned op, lat, inj, gap;
    logic [26:0] ln;
    logic [LINE_W-1:0] wd, exp_data;
    logic is_wr, is_rd, oor, exp_v;
    for (int unsigned t = 0; t < 80; t++) begin
      op    = $urandom_range(0, 3);
      is_wr = (op == 1) || (op == 2);
      is_rd = (op != 1);
      ln    = ($urandom_range(0, 3) == 0) ? 27'(MEM_RANGE + $urandom_range(0, 3)) : 27'($urandom_range(0, 7));
      oor   = (32'(ln) >= MEM_RANGE);
      wd    = rand_line();
      lat   = is_wr ? WR_LAT : RD_LAT;
      inj   = $urandom_range(0, lat);
      exp_data = model_read({ln, 5'd0});
      mm_a = {ln, 5'($urandom)}; mm_wd = wd; mm_read = is_rd; mm_write = is_wr;
      step();
      mm_read = 1'b0; mm_write = 1'b0;
      vectors++;
      if ({mm_valid, busy, err} !== {2'b01, (op == 2) || oor}) begin
        miscompares++;
        $display("FAIL rnd_accept t%0d op%0d got v/b/e=%b required %b", t, op, {mm_valid, busy, err}, {2'b01, (op == 2) || oor});
      end
      for (int unsigned m = 1; m <= lat; m++) begin
        if (m == inj) begin
          mm_a = $urandom; mm_wd = rand_line();
          if ($urandom_range(0, 1) == 0) mm_read = 1'b1; else mm_write = 1'b1;
        end
        step();
        mm_read = 1'b0; mm_write = 1'b0;
        exp_v = !is_wr && (m == lat);
        vectors++;
        if ({mm_valid, busy, err} !== {exp_v, m < lat, m == inj}) begin
          miscompares++;
          $display("FAIL rnd_flags t%0d cyc%0d got v/b/e=%b required %b", t, m, {mm_valid, busy, err}, {exp_v, m < lat, m == inj});
        end
        vectors++;
        if (mm_rd !== (exp_v ? exp_data : {LINE_W{1'b0}})) begin
          miscompares++;
          $display("FAIL rnd_data t%0d cyc%0d got %h required %h", t, m, mm_rd, exp_v ? exp_data : {LINE_W{1'b0}});
        end
`ifdef MM_RESP_WRACK_EN
        vectors++;
        if (wr_ack !== (is_wr && (m == lat))) begin
          miscompares++;
          $display("FAIL rnd_wrack t%0d cyc%0d got %b required %b", t, m, wr_ack, is_wr && (m == lat));
        end
`endif
      end
      if (is_wr && !oor) model_mem[ln[7:0]] = wd;
      gap = $urandom_range(0, 2);
      for (int unsigned g = 0; g < gap; g++) begin
        step();
        vectors++;
        if ({mm_valid, busy, err} !== 3'b000) begin
          miscompares++;
          $display("FAIL rnd_idle t%0d got v/b/e=%b required 000", t, {mm_valid, busy, err});
        end
      end
    end
  endtask

  initial begin
    for (int unsigned i = 0; i < MEM_RANGE; i++) model_mem[i] = boot_line(i);
    test_reset();
    test_read_latency();
    test_write_then_read();
    test_busy_drop();
    test_rw_conflict();
    test_out_of_range();
    test_reset_mid_write();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
